// File: rtl/miner_pkg.sv
// Shared constants and state encoding for the miner header/nonce feeder.
package miner_pkg;

  localparam int MAX_WORDS      = 250;
  localparam int NONCE_BYTE_LEN = 24;
  localparam int ADDR_W         = 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    GUARD,
    WAIT,
    DECIDE
  } feeder_state_t;

endpackage

// File: rtl/miner_feeder_header_ram.sv
// Header word store: synchronous write, asynchronous read so the miner sees
// the word under the pointer in the same cycle it pops.
module header_ram #(
  parameter int DEPTH  = 250,
  parameter int ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge Clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/miner_feeder.sv
// Launches miner attempts, serves header words on request and walks the nonce
// until the miner reports a hit or the host asks to stop.
module miner_feeder #(
  parameter int NONCE_BYTE_LEN = miner_pkg::NONCE_BYTE_LEN,
  parameter int MAX_WORDS      = miner_pkg::MAX_WORDS,
  parameter int ADDR_W         = miner_pkg::ADDR_W
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic                        Wr_I,
  input  logic [ADDR_W-1:0]           WrAddr_I,
  input  logic [31:0]                 WrData_I,
  input  logic [10:0]                 ByteNum_I,
  input  logic [NONCE_BYTE_LEN*8-1:0] NonceStart_I,
  input  logic                        Start_I,
  input  logic                        Stop_I,
  output logic                        Update_O,
  output logic [31:0]                 Msg_O,
  output logic [10:0]                 ByteNum_O,
  output logic [NONCE_BYTE_LEN*8-1:0] Nonce_O,
  input  logic                        Next_I,
  input  logic                        Rdy_I,
  input  logic                        Vld_I,
  output logic                        Busy_O,
  output logic                        Found_O,
  output logic [NONCE_BYTE_LEN*8-1:0] FoundNonce_O,
  output logic [31:0]                 Tries_O
);
  import miner_pkg::*;

  localparam int NW = NONCE_BYTE_LEN * 8;
  localparam logic [ADDR_W-1:0] MAX_PTR = ADDR_W'(MAX_WORDS);

  feeder_state_t     state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [NW-1:0]     nonce_q, nonce_d;
  logic [NW-1:0]     found_nonce_q, found_nonce_d;
  logic [10:0]       bytenum_q, bytenum_d;
  logic [31:0]       tries_q, tries_d;
  logic              found_q, found_d;
  logic              stop_q, stop_d;
  logic              vld_q, vld_d;
  logic              serving;
  logic              ram_we;
  logic [31:0]       ram_rdata;

  assign serving = (state_q == GUARD) || (state_q == WAIT);
  assign ram_we  = Wr_I && (state_q == IDLE) && (WrAddr_I < MAX_PTR);

  header_ram #(
    .DEPTH  (MAX_WORDS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .Clk     (Clk),
    .we_i    (ram_we),
    .waddr_i (WrAddr_I),
    .wdata_i (WrData_I),
    .raddr_i (ptr_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      nonce_q       <= '0;
      found_nonce_q <= '0;
      bytenum_q     <= '0;
      tries_q       <= '0;
      found_q       <= 1'b0;
      stop_q        <= 1'b0;
      vld_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      nonce_q       <= nonce_d;
      found_nonce_q <= found_nonce_d;
      bytenum_q     <= bytenum_d;
      tries_q       <= tries_d;
      found_q       <= found_d;
      stop_q        <= stop_d;
      vld_q         <= vld_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    nonce_d       = nonce_q;
    found_nonce_d = found_nonce_q;
    bytenum_d     = bytenum_q;
    tries_d       = tries_q;
    found_d       = found_q;
    stop_d        = stop_q;
    vld_d         = vld_q;

    if (Stop_I && (state_q != IDLE)) begin
      stop_d = 1'b1;
    end
    if (serving && Next_I && (ptr_q < MAX_PTR)) begin
      ptr_d = ptr_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (Start_I) begin
          bytenum_d = ByteNum_I;
          nonce_d   = NonceStart_I;
          found_d   = 1'b0;
          tries_d   = '0;
          stop_d    = 1'b0;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        ptr_d   = '0;
        state_d = GUARD;
      end
      // The miner still shows the previous attempt's Rdy here.
      GUARD: state_d = WAIT;
      WAIT: begin
        if (Rdy_I) begin
          vld_d   = Vld_I;
          state_d = DECIDE;
        end
      end
      DECIDE: begin
        if (tries_q != '1) begin
          tries_d = tries_q + 32'd1;
        end
        if (vld_q) begin
          found_d       = 1'b1;
          found_nonce_d = nonce_q;
          state_d       = IDLE;
        end else if (stop_q) begin
          state_d = IDLE;
        end else begin
          nonce_d = nonce_q + NW'(1);
          state_d = LAUNCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Update_O     = (state_q == LAUNCH);
  assign Busy_O       = (state_q != IDLE);
  assign Msg_O        = (serving && (ptr_q < MAX_PTR)) ? ram_rdata : 32'h0;
  assign ByteNum_O    = bytenum_q;
  assign Nonce_O      = nonce_q;
  assign Found_O      = found_q;
  assign FoundNonce_O = found_nonce_q;
  assign Tries_O      = tries_q;

endmodule

// File: tb/tb_miner_feeder.sv
// Randomised bench: a miner model drives requests/results, expectations go to
// queues, and a negedge monitor checks launches, served words and search results.
module tb_miner_feeder;

  localparam int NW = 192;
  localparam int MW = 250;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          Rst_n, Wr_I, Start_I, Stop_I, Next_I, Rdy_I, Vld_I;
  logic [AW-1:0] WrAddr_I;
  logic [31:0]   WrData_I;
  logic [10:0]   ByteNum_I;
  logic [NW-1:0] NonceStart_I;
  logic          Update_O, Busy_O, Found_O;
  logic [31:0]   Msg_O, Tries_O;
  logic [10:0]   ByteNum_O;
  logic [NW-1:0] Nonce_O, FoundNonce_O;

  always #5 clk = ~clk;

  miner_feeder dut (
    .Clk(clk), .Rst_n(Rst_n), .Wr_I(Wr_I), .WrAddr_I(WrAddr_I), .WrData_I(WrData_I),
    .ByteNum_I(ByteNum_I), .NonceStart_I(NonceStart_I), .Start_I(Start_I), .Stop_I(Stop_I),
    .Update_O(Update_O), .Msg_O(Msg_O), .ByteNum_O(ByteNum_O), .Nonce_O(Nonce_O),
    .Next_I(Next_I), .Rdy_I(Rdy_I), .Vld_I(Vld_I), .Busy_O(Busy_O), .Found_O(Found_O),
    .FoundNonce_O(FoundNonce_O), .Tries_O(Tries_O)
  );

  typedef struct { logic [NW-1:0] nonce; logic [10:0] bnum; } launch_t;
  typedef struct { logic found; logic [NW-1:0] fn; logic [31:0] tries; } result_t;

  launch_t       exp_launch[$];
  logic [31:0]   exp_msg[$];
  result_t       exp_res[$];
  logic [31:0]   model_buf [MW];
  logic [NW-1:0] last_found;
  int            checks = 0;
  int            failures = 0;
  bit            prev_busy = 1'b0;

  function automatic logic [NW-1:0] rand192();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [NW-1:0] act, input logic [NW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: pops one expectation per DUT event.
  launch_t m_l;
  result_t m_r;
  logic [31:0] m_w;
  always @(negedge clk) begin
    if (Update_O === 1'b1) begin
      if (exp_launch.size() == 0) begin
        checks++; failures++;
        $display("FAIL update_unexpected nonce=%h", Nonce_O);
      end else begin
        m_l = exp_launch.pop_front();
        chk("launch_nonce", Nonce_O, m_l.nonce);
        chk("launch_bytenum", NW'(ByteNum_O), NW'(m_l.bnum));
        $display("launch nonce=%h bytenum=%0d", Nonce_O, ByteNum_O);
      end
    end
    if (Next_I === 1'b1) begin
      if (exp_msg.size() == 0) begin
        checks++; failures++;
        $display("FAIL msg_unexpected actual=%h", Msg_O);
      end else begin
        m_w = exp_msg.pop_front();
        chk("msg_word", NW'(Msg_O), NW'(m_w));
      end
    end
    if (prev_busy && (Busy_O === 1'b0)) begin
      if (exp_res.size() == 0) begin
        checks++; failures++;
        $display("FAIL result_unexpected tries=%0d", Tries_O);
      end else begin
        m_r = exp_res.pop_front();
        chk("res_found", NW'(Found_O), NW'(m_r.found));
        chk("res_found_nonce", FoundNonce_O, m_r.fn);
        chk("res_tries", NW'(Tries_O), NW'(m_r.tries));
        $display("result found=%0d nonce=%h tries=%0d", Found_O, FoundNonce_O, Tries_O);
      end
    end
    prev_busy = (Busy_O === 1'b1);
  end

  task automatic write_word(input logic [AW-1:0] a, input logic [31:0] d);
    Wr_I = 1'b1; WrAddr_I = a; WrData_I = d;
    tick();
    Wr_I = 1'b0;
    if (int'(a) < MW) model_buf[a] = d;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_update"}, NW'(Update_O), '0);
    chk({tag, "_busy"}, NW'(Busy_O), '0);
    chk({tag, "_found"}, NW'(Found_O), '0);
    chk({tag, "_found_nonce"}, FoundNonce_O, '0);
    chk({tag, "_tries"}, NW'(Tries_O), '0);
    chk({tag, "_nonce"}, Nonce_O, '0);
    chk({tag, "_bytenum"}, NW'(ByteNum_O), '0);
    chk({tag, "_msg"}, NW'(Msg_O), '0);
  endtask

  task automatic wait_update(output bit ok);
    int t = 0;
    while (Update_O !== 1'b1 && t < 20) begin tick(); t++; end
    ok = (t < 20);
    if (!ok) begin
      checks++; failures++;
      $display("FAIL launch_timeout actual=no_update required=update");
    end
  endtask

  // One search: attempt k succeeds if k==win_k, the stop request lands in attempt stop_k.
  task automatic run_search(input logic [NW-1:0] start, input logic [10:0] bn, input int win_k,
                            input int stop_k, input bit stop_same, input int pops0, input bit poke);
    int k = 0;
    bit done = 1'b0;
    bit ok, win, stp;
    int npops;
    Start_I = 1'b1; ByteNum_I = bn; NonceStart_I = start;
    tick();
    Start_I = 1'b0; ByteNum_I = 11'($urandom); NonceStart_I = rand192();
    while (!done) begin
      exp_launch.push_back('{start + NW'(k), bn});
      wait_update(ok);
      if (!ok) return;
      tick();
      npops = (k == 0) ? pops0 : $urandom_range(0, 12);
      for (int j = 0; j < ((npops > 1) ? npops : 1); j++) begin
        Next_I = (j < npops);
        if (j < npops) exp_msg.push_back((j < MW) ? model_buf[j] : 32'h0);
        Rdy_I = (j == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        Vld_I = Rdy_I;
        tick();
      end
      Next_I = 1'b0; Rdy_I = 1'b0; Vld_I = 1'b0;
      win = (k == win_k);
      stp = (k == stop_k);
      Stop_I = stp && !stop_same;
      if (poke) begin
        Wr_I = 1'b1; WrAddr_I = AW'($urandom_range(0, 15)); WrData_I = $urandom;
        Start_I = 1'b1; NonceStart_I = rand192();
      end
      tick();
      Stop_I = 1'b0; Wr_I = 1'b0; Start_I = 1'b0;
      Rdy_I = 1'b1; Vld_I = win; Stop_I = stp && stop_same;
      tick();
      Rdy_I = 1'b0; Vld_I = 1'b0; Stop_I = 1'b0;
      if (win || stp) begin
        exp_res.push_back('{win, win ? start + NW'(k) : last_found, 32'(k + 1)});
        if (win) last_found = start + NW'(k);
        done = 1'b1;
        tick();
        tick();
      end else begin
        k++;
      end
    end
  endtask

  task automatic reset_mid_search();
    bit ok;
    Start_I = 1'b1; ByteNum_I = 11'd40; NonceStart_I = rand192();
    exp_launch.push_back('{NonceStart_I, 11'd40});
    tick();
    Start_I = 1'b0;
    wait_update(ok);
    tick();
    tick();
    exp_res.push_back('{1'b0, '0, 32'd0});
    last_found = '0;
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    check_all_zero("midrst");
    Rdy_I = 1'b1; Vld_I = 1'b1;
    repeat (3) tick();
    Rdy_I = 1'b0; Vld_I = 1'b0;
    chk("stale_rdy_busy", NW'(Busy_O), '0);
    chk("stale_rdy_found", NW'(Found_O), '0);
  endtask

  initial begin
    Rst_n = 1'b0; Wr_I = 1'b0; WrAddr_I = '0; WrData_I = '0; ByteNum_I = '0;
    NonceStart_I = '0; Start_I = 1'b0; Stop_I = 1'b0; Next_I = 1'b0;
    Rdy_I = 1'b0; Vld_I = 1'b0;
    last_found = '0;
    tick(); tick();
    Rst_n = 1'b1;
    check_all_zero("reset");

    for (int i = 0; i < MW; i++) write_word(AW'(i), $urandom);
    for (int i = 0; i <= 10; i++) write_word(AW'(i), 32'hA0 + 32'(i));
    write_word(AW'(250), 32'hDEAD_BEEF);

    // Three misses then a hit from nonce 5; host pokes while busy are ignored.
    run_search(NW'(5), 11'd64, 3, -1, 1'b0, 11, 1'b1);
    chk("dir_found", NW'(Found_O), NW'(1));
    chk("dir_found_nonce", FoundNonce_O, NW'(8));
    chk("dir_tries", NW'(Tries_O), NW'(4));
    chk("dir_busy", NW'(Busy_O), '0);

    run_search('1, 11'd64, 1, -1, 1'b0, 10, 1'b0);
    chk("wrap_found_nonce", FoundNonce_O, '0);
    run_search(rand192(), 11'd80, -1, 0, 1'b0, 3, 1'b0);
    chk("stop_tries", NW'(Tries_O), NW'(1));
    chk("stop_found", NW'(Found_O), '0);
    run_search(rand192(), 11'd80, 2, 2, 1'b1, 4, 1'b0);
    run_search(rand192(), 11'd0, -1, 1, 1'b1, 0, 1'b0);
    run_search(rand192(), 11'd1000, 0, -1, 1'b0, 252, 1'b0);
    reset_mid_search();

    for (int it = 0; it < 10; it++) begin
      for (int w = 0; w < 4; w++) write_word(AW'($urandom_range(0, 255)), $urandom);
      run_search(rand192(), 11'($urandom), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4)) : -1,
                 1'($urandom_range(0, 1)), $urandom_range(0, 14), 1'($urandom_range(0, 1)));
    end

    repeat (3) tick();
    chk("queues_drained", NW'(exp_launch.size() + exp_msg.size() + exp_res.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/miner_feeder.md
# miner_feeder

Host-side controller that drives the miner's header/nonce interface. It stores the header blob in a local word buffer and launches a hash attempt by pulsing `Update_O`. It serves header words on the miner's `Next_I` requests, then collects `Rdy_I`/`Vld_I` and either reports a winning nonce or increments the nonce and relaunches. It sits between the host register bus and a single miner instance.

## Interface
Parameters:
- `NONCE_BYTE_LEN`, default 24: nonce length in bytes; the nonce is 192 bits when this is 24.
- `MAX_WORDS`, default 250: header buffer depth in 32-bit words (1000 bytes).
- `ADDR_W`, default 8: buffer address width.

Ports:
- `Clk`  in  1  the single clock.
- `Rst_n`  in  1  reset, synchronous, active-low.
- `Wr_I`  in  1  host buffer write strobe.
- `WrAddr_I`  in  ADDR_W  write word address.
- `WrData_I`  in  32  write data, already in miner byte order.
- `ByteNum_I`  in  11  total message bytes, nonce included.
- `NonceStart_I`  in  NONCE_BYTE_LEN*8  first nonce to try.
- `Start_I`  in  1  begin a search.
- `Stop_I`  in  1  end the search at the next attempt boundary.
- `Update_O`  out  1  one-cycle launch pulse to the miner.
- `Msg_O`  out  32  current header word (show-ahead).
- `ByteNum_O`  out  11  latched `ByteNum_I`.
- `Nonce_O`  out  NONCE_BYTE_LEN*8  nonce under test.
- `Next_I`  in  1  miner word request/pop.
- `Rdy_I`  in  1  miner attempt complete.
- `Vld_I`  in  1  miner nonce meets target.
- `Busy_O`  out  1  a search is in progress.
- `Found_O`  out  1  sticky; a winning nonce was found.
- `FoundNonce_O`  out  NONCE_BYTE_LEN*8  winning nonce.
- `Tries_O`  out  32  completed attempts in the current search.

## Operation
- States:
  - `IDLE`: sits here after reset and after every search.
  - `LAUNCH`: asserts `Update_O` for one cycle.
  - `GUARD`: lasts one cycle; `Rdy_I` is ignored here because the miner clears its stale `Rdy` on the cycle after `Update`.
  - `WAIT`: waits for the miner result.
  - `DECIDE`: acts on the result for one cycle.
- Transitions:
  - `IDLE` → `LAUNCH` on `Start_I`. On the same edge: latch `ByteNum_I` and `NonceStart_I`, clear `Found_O` and `Tries_O`, clear the stop flag.
  - `LAUNCH` → `GUARD` → `WAIT`.
  - `WAIT` → `DECIDE` when `Rdy_I`=1. `Vld_I` is sampled on that same cycle.
  - `DECIDE` with `Vld_I`=1: set `Found_O`, set `FoundNonce_O`=`Nonce_O`, go to `IDLE`.
  - `DECIDE` with `Vld_I`=0 and the stop flag set: go to `IDLE`.
  - `DECIDE` with `Vld_I`=0 and the stop flag clear: `Nonce_O`+1, then go to `LAUNCH`. The increment is unsigned over the full nonce width and wraps to 0.
  - `Tries_O` increments in every `DECIDE`. It saturates at all-ones.
- Stop flag:
  - Set by `Stop_I` in any non-`IDLE` state.
  - `Stop_I` in `IDLE` has no effect.
- Word serving:
  - The read pointer clears to 0 in `LAUNCH`.
  - The buffer holds the header words that follow the nonce.
  - `Msg_O` = buffer[ptr] combinationally, the same cycle as `Next_I`. The miner samples it on that edge.
  - On `Next_I`: ptr+1, saturating at `MAX_WORDS`.
  - When ptr ≥ `MAX_WORDS`, `Msg_O`=0.
  - `Next_I` outside `GUARD`/`WAIT` is ignored.
- Host writes:
  - Accepted only in `IDLE`; ignored while `Busy_O`=1.
  - Writes with `WrAddr_I` ≥ `MAX_WORDS` are dropped.
- `Start_I` while busy: ignored.
- `Busy_O` = state ≠ `IDLE`.

## Timing
- Reset value of every output is 0, as is the buffer pointer. Buffer contents are not reset.
- Launch: `Update_O` rises one cycle after the `Start_I` edge.
- Relaunch: `DECIDE` to the next `Update_O` is 1 cycle, so the controller overhead is 3 cycles per attempt beyond the miner latency.
- Reset asserted mid-search: on the next edge, return to `IDLE` with all outputs 0. No `Update_O` is issued.
- `Rdy_I` and `Stop_I` on the same cycle in `WAIT`: the result is still evaluated, so a winning nonce is reported; otherwise the search stops.
- `Vld_I` without `Rdy_I`: ignored.
- `ByteNum_I`=0: the launch proceeds normally. The miner requests no words.

## Structure
- Package `miner_pkg`: `feeder_state_t` enum, `MAX_WORDS`, `NONCE_BYTE_LEN` constants.
- Sub-module `header_ram`: `MAX_WORDS`×32 register file, synchronous write, asynchronous read.
- The FSM, pointer, nonce and counters live in `miner_feeder`.

## Test plan
- Write words 0..9 = 0xA0..0xA9, `ByteNum_I`=64, `Start_I` → one `Update_O` pulse. Ten `Next_I` pops return 0xA0..0xA9 in order; an 11th pop returns 0xAA's slot value.
- Model miner asserts `Rdy_I`=1, `Vld_I`=0 three times, then `Vld_I`=1, with `NonceStart_I`=5 → `FoundNonce_O`=8, `Tries_O`=4, `Found_O`=1, `Busy_O`=0.
- `NonceStart_I`=all-ones, one failed attempt → next `Nonce_O`=0.
- `Stop_I` pulsed during `WAIT`; attempt ends with `Vld_I`=0 → `IDLE`, no further `Update_O`, `Tries_O`=1.
- `Rst_n`=0 for one cycle during `WAIT` → all outputs 0 on the next edge; a stale `Rdy_I` afterwards causes no action.
- `Wr_I` while busy → the write is ignored (readback unchanged in the next search); `WrAddr_I`=250 dropped.
